// File: rtl/uart_pkg.sv
// uart_pkg: shared types, default widths and frame helpers for the UART transmit path
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int UART_DIV_WIDTH  = 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    function automatic int frame_cycles(input logic par_en, input logic two_stop,
                                        input int unsigned div, input int dw = UART_DATA_WIDTH);
        return (2 + dw + int'(par_en) + int'(two_stop)) * (int'(div) + 1);
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: registered read port between the TX FIFO and the transmit controller
interface uart_tx_ctrl_if import uart_pkg::*; #(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_rd_en;

    modport master (output fifo_rd_en, input fifo_empty, input fifo_data);
    modport slave  (input fifo_rd_en, output fifo_empty, output fifo_data);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: loadable down-counter marking the last cycle of each bit period
module uart_baud_tick import uart_pkg::*; #(
    parameter int DIV_WIDTH = UART_DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 bit_end
);
    logic [DIV_WIDTH-1:0] cnt;

    assign bit_end = cnt == '0;

    // reload on an explicit restart or when a bit period expires, otherwise count down
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else
            cnt <= (load || bit_end) ? div : cnt - DIV_WIDTH'(1);
    end
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: drains the TX FIFO and serializes each byte as a start/data/parity/stop frame
module uart_tx_ctrl import uart_pkg::*; #(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DIV_WIDTH  = UART_DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_en,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 two_stop,
    uart_tx_ctrl_if.master       fifo,
    output logic                 txd,
    output logic                 busy,
    output logic                 frame_done
);
    localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;

    tx_state_t             state, next;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [BW-1:0]         bit_cnt_q;
    logic                  stop_cnt_q;
    logic                  par_en_q;
    logic                  two_stop_q;
    logic                  par_bit_q;
    logic                  bit_end;
    logic                  more;

    assign more = tx_en && !fifo.fifo_empty;

    // the timer restarts from the live divisor in LOAD, from the latched one afterwards
    uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .load    (state == LOAD),
        .div     (state == LOAD ? baud_div : div_q),
        .bit_end (bit_end)
    );

    // state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next;
    end

    // next-state decode and Moore strobes
    always_comb begin
        next       = state;
        frame_done = 1'b0;
        fifo.fifo_rd_en = state == FETCH;
        busy       = state != IDLE;
        case (state)
            IDLE:    next = more ? FETCH : IDLE;
            FETCH:   next = LOAD;
            LOAD:    next = START;
            START:   next = bit_end ? DATA : START;
            DATA:    next = (bit_end && bit_cnt_q == BW'(DATA_WIDTH - 1)) ? (par_en_q ? PARITY : STOP) : DATA;
            PARITY:  next = bit_end ? STOP : PARITY;
            STOP: begin
                if (bit_end && (stop_cnt_q || !two_stop_q)) begin
                    frame_done = 1'b1;
                    next       = more ? FETCH : IDLE;
                end
            end
            default: next = IDLE;
        endcase
    end

    // frame capture, shifting, bit/stop counting and the registered serial output
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q    <= '0;
            div_q      <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            par_bit_q  <= 1'b0;
            txd        <= 1'b1;
        end else begin
            if (state == LOAD) begin
                shift_q    <= fifo.fifo_data;
                div_q      <= baud_div;
                par_en_q   <= parity_en;
                two_stop_q <= two_stop;
                par_bit_q  <= (^fifo.fifo_data) ^ parity_odd;
                bit_cnt_q  <= '0;
                stop_cnt_q <= 1'b0;
            end
            if (state == DATA && bit_end) begin
                shift_q   <= shift_q >> 1;
                bit_cnt_q <= bit_cnt_q + BW'(1);
            end
            if (state == STOP && bit_end)
                stop_cnt_q <= 1'b1;
            txd <= state == START ? 1'b0 : state == DATA ? shift_q[0] : state == PARITY ? par_bit_q : 1'b1;
        end
    end
endmodule
